// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and load writebacks onto the single regfile write port.
// Define RF_WB_STARVE_GUARD_EN to force-grant the ALU after STARVE_MAX consecutive denials.
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [4:0]       ld_rd,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [31:0]      rf_wd,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic alu_win;
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end
`ifdef RF_WB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  always_comb alu_win = alu_valid && (!ld_valid || starve_cnt == 4'(STARVE_MAX));
  always_ff @(posedge clk) begin
    if (!reset_n) starve_cnt <= '0;
    else if (!alu_valid || alu_ready) starve_cnt <= '0;
    else if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  always_comb alu_win = alu_valid && !ld_valid;
`endif
  // Readies are forced low throughout reset so nothing is accepted and lost.
  assign alu_ready = reset_n && alu_win;
  assign ld_ready  = reset_n && ld_valid && !alu_win;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we        <= 1'b0;
      rf_wa        <= '0;
      rf_wd        <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_we <= alu_ready ? |alu_rd : ld_ready ? |ld_rd : 1'b0;
      if (alu_ready || ld_ready) begin
        rf_wa <= alu_ready ? alu_rd : ld_rd;
        rf_wd <= alu_ready ? alu_data : ld_data;
      end
      if (alu_valid && ld_valid) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
endmodule
